// File: rtl/decoder_scan_ctrl_if.sv
// Control and output bundle between a scan sequencer and its 2x4 decoder.
// master drives run/mask and observes the scan; slave is the sequencer side.
interface decoder_scan_ctrl_if;
    logic       run;
    logic [3:0] mask;
    logic [1:0] x;
    logic       e;
    logic       wrap;
    logic       busy;

    modport master (output run, output mask, input x, input e, input wrap, input busy);
    modport slave  (input run, input mask, output x, output e, output wrap, output busy);
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Purpose: scans x through enabled mask codes, e high DWELL cycles then BLANK cycles low.
// Latency: run/mask act on the next clock edge; all outputs are registered.
// Backpressure: none; run=0 abandons the current dwell and blanks on the next edge.
module decoder_scan_ctrl #(
    parameter int DWELL = 8,
    parameter int BLANK = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_scan_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LD = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [1:0]       x_q;
    logic             e_q;
    logic             wrap_q;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       first_code;
    logic [1:0]       next_code;
    logic             mask_any;
    logic             code_boundary;

    assign mask_any = |bus.mask;

    always_comb begin
        first_code = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.mask[k]) first_code = 2'(k);
        end
    end

    // Cyclic search x+1, x+2, x+3, x: the lowest offset with its bit set wins.
    always_comb begin
        next_code = x_q;
        for (int k = 4; k >= 1; k--) begin
            if (bus.mask[2'(x_q + 2'(k))]) next_code = 2'(x_q + 2'(k));
        end
    end

    // A new code is chosen at the end of the gap, or at the end of the dwell when there is no gap.
    always_comb begin
        code_boundary = 1'b0;
        if (cnt == '0) begin
            if (state == GAP)                  code_boundary = 1'b1;
            if (state == SHOW && BLANK == 0)   code_boundary = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            x_q    <= 2'd0;
            e_q    <= 1'b0;
            wrap_q <= 1'b0;
            cnt    <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (state != IDLE && !bus.run) begin
                state <= IDLE;
                e_q   <= 1'b0;
                cnt   <= '0;
            end else if (code_boundary) begin
                if (!mask_any) begin
                    state <= IDLE;
                    e_q   <= 1'b0;
                    cnt   <= '0;
                end else begin
                    state  <= SHOW;
                    x_q    <= next_code;
                    e_q    <= 1'b1;
                    cnt    <= DWELL_LD;
                    wrap_q <= (next_code <= x_q);
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.run && mask_any) begin
                            state <= SHOW;
                            x_q   <= first_code;
                            e_q   <= 1'b1;
                            cnt   <= DWELL_LD;
                        end
                    end
                    SHOW: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_ONE;
                        end else begin
                            state <= GAP;
                            e_q   <= 1'b0;
                            cnt   <= BLANK_LD;
                        end
                    end
                    GAP: begin
                        cnt <= cnt - CNT_ONE;
                    end
                    default: begin
                        state <= IDLE;
                        e_q   <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.x    = x_q;
    assign bus.e    = e_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: two instances (DWELL=4/BLANK=2 and DWELL=1/BLANK=0)
// checked every cycle against a period/age model, plus hand-computed spot values.
module tb_decoder_scan_ctrl;

    logic clk;
    logic rst;
    logic       run_v  [2];
    logic [3:0] mask_v [2];
    logic [1:0] o_x [2];
    logic       o_e [2];
    logic       o_w [2];
    logic       o_b [2];

    decoder_scan_ctrl_if if_a ();
    decoder_scan_ctrl_if if_b ();

    assign if_a.run  = run_v[0];
    assign if_a.mask = mask_v[0];
    assign if_b.run  = run_v[1];
    assign if_b.mask = mask_v[1];
    assign o_x[0] = if_a.x;  assign o_e[0] = if_a.e;  assign o_w[0] = if_a.wrap;  assign o_b[0] = if_a.busy;
    assign o_x[1] = if_b.x;  assign o_e[1] = if_b.e;  assign o_w[1] = if_b.wrap;  assign o_b[1] = if_b.busy;

    decoder_scan_ctrl #(.DWELL(4), .BLANK(2), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    decoder_scan_ctrl #(.DWELL(1), .BLANK(0), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit done   = 1'b0;

    // Model: a scan is "active" with a current code and an age inside its DWELL+BLANK period.
    int         DW [2] = '{4, 1};
    int         BL [2] = '{2, 0};
    bit         m_act [2] = '{1'b0, 1'b0};
    logic [1:0] m_cur [2] = '{2'd0, 2'd0};
    int         m_age [2] = '{0, 0};
    bit         m_wf  [2] = '{1'b0, 1'b0};

    function automatic logic [1:0] low_code(logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[k]) return 2'(k);
        return 2'd0;
    endfunction

    function automatic logic [1:0] next_from(logic [1:0] cur, logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] c;
            c = 2'((int'(cur) + k) % 4);
            if (m[c]) return c;
        end
        return cur;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 1'b0; m_cur[i] = 2'd0; m_age[i] = 0; m_wf[i] = 1'b0;
            end else if (!m_act[i]) begin
                if (run_v[i] && mask_v[i] != 4'd0) begin
                    m_act[i] = 1'b1; m_cur[i] = low_code(mask_v[i]); m_age[i] = 0; m_wf[i] = 1'b0;
                end
            end else if (!run_v[i]) begin
                m_act[i] = 1'b0;
            end else if (m_age[i] == DW[i] + BL[i] - 1) begin
                if (mask_v[i] == 4'd0) begin
                    m_act[i] = 1'b0;
                end else begin
                    logic [1:0] nc;
                    nc = next_from(m_cur[i], mask_v[i]);
                    m_wf[i]  = (nc <= m_cur[i]);
                    m_cur[i] = nc;
                    m_age[i] = 0;
                end
            end else begin
                m_age[i] = m_age[i] + 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    function automatic logic [4:0] expected(int i);
        logic e, w;
        e = m_act[i] && (m_age[i] < DW[i]);
        w = m_act[i] && (m_age[i] == 0) && m_wf[i];
        return {m_cur[i], e, w, m_act[i]};
    endfunction

    function automatic logic [4:0] dut_out(int i);
        return {o_x[i], o_e[i], o_w[i], o_b[i]};
    endfunction

    task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got {x,e,wrap,busy}=%b required %b at %0t", name, act, exp, $time);
    endtask

    initial forever begin
        @(negedge clk);
        if (!done) begin
            chk("a_cycle", dut_out(0), expected(0));
            chk("b_cycle", dut_out(1), expected(1));
        end
    end

    task automatic wait_edges(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        run_v[0] = 1'b0; run_v[1] = 1'b0;
        mask_v[0] = 4'd0; mask_v[1] = 4'd0;
        #3;
        chk("a_reset", dut_out(0), 5'b00_0_0_0);
        chk("b_reset", dut_out(1), 5'b00_0_0_0);
        wait_edges(2);
        rst = 1'b0;
        run_v[0] = 1'b1; run_v[1] = 1'b1;
        mask_v[0] = 4'hF; mask_v[1] = 4'hF;

        wait_edges(1);                                  // E1
        chk("a_start", dut_out(0), 5'b00_1_0_1);
        chk("b_start", dut_out(1), 5'b00_1_0_1);
        wait_edges(3);                                  // E4
        chk("a_dwell_end", dut_out(0), 5'b00_1_0_1);
        chk("b_code3", dut_out(1), 5'b11_1_0_1);
        wait_edges(1);                                  // E5
        chk("a_gap", dut_out(0), 5'b00_0_0_1);
        chk("b_wrap", dut_out(1), 5'b00_1_1_1);
        wait_edges(2);                                  // E7
        chk("a_code1", dut_out(0), 5'b01_1_0_1);
        wait_edges(1);                                  // E8: second SHOW cycle of x=1
        run_v[0] = 1'b0;
        wait_edges(1);                                  // E9
        chk("a_run_drop", dut_out(0), 5'b01_0_0_0);
        run_v[0] = 1'b1;
        wait_edges(1);                                  // E10
        chk("a_restart", dut_out(0), 5'b00_1_0_1);
        wait_edges(24);                                 // E34: second visit to code 0
        chk("a_second_visit", dut_out(0), 5'b00_1_1_1);
        mask_v[0] = 4'b0100;
        mask_v[1] = 4'b0000;
        wait_edges(6);                                  // E40
        chk("a_single_first", dut_out(0), 5'b10_1_0_1);
        chk("b_mask_zero", dut_out(1), 5'b01_0_0_0);
        wait_edges(6);                                  // E46
        chk("a_single_repeat", dut_out(0), 5'b10_1_1_1);

        rst = 1'b1;
        #1;
        chk("a_async_rst", dut_out(0), 5'b00_0_0_0);
        chk("b_async_rst", dut_out(1), 5'b00_0_0_0);
        wait_edges(1);
        rst = 1'b0;
        mask_v[0] = 4'hF; mask_v[1] = 4'hF;
        wait_edges(1);
        chk("a_after_rst", dut_out(0), 5'b00_1_0_1);
        chk("b_after_rst", dut_out(1), 5'b00_1_0_1);

        mask_v[0] = 4'b0101; mask_v[1] = 4'b0101;
        wait_edges(60);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            wait_edges(1);
            if (rst) rst = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (run_v[i]) begin
                    if ($urandom_range(39) == 0) run_v[i] = 1'b0;
                end else if ($urandom_range(4) == 0) begin
                    run_v[i] = 1'b1;
                end
                if ($urandom_range(59) == 0) mask_v[i] = 4'($urandom_range(15));
            end
            if ($urandom_range(699) == 0) begin
                rst = 1'b1;
                #1;
                chk("rand_async_rst_a", dut_out(0), 5'b00_0_0_0);
            end
        end

        wait_edges(1);
        rst = 1'b0;
        @(negedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
